// File: rtl/weight_stager.sv
// Double-buffered 2x2 weight tile stager: shadow bank accepts a tile, stage bank shifts it into the array.
// Latency: accept at edge N -> w_shift in cycles N+2/N+3, act_valid from N+4; backpressure via in_ready = shadow empty.
module weight_stager (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] weight1,
    input  logic [7:0] weight2,
    input  logic [7:0] weight3,
    input  logic [7:0] weight4,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       tile_done,
    output logic [7:0] w_col0,
    output logic [7:0] w_col1,
    output logic       w_shift,
    output logic       act_valid,
    output logic [7:0] tiles_loaded,
    output logic       err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT0 = 2'd1;
    localparam logic [1:0] SHIFT1 = 2'd2;
    localparam logic [1:0] ACTIVE = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [3:0][7:0] shadow_q;
    logic [3:0][7:0] stage_q;
    logic            shadow_full;
    logic            promote;
    logic            accept;

    assign in_ready = ~shadow_full;
    assign accept   = in_valid & ~shadow_full;

    // promote marks the edge where the shadow tile moves into the stage bank
    always_comb begin
        state_nxt = state;
        promote   = 1'b0;
        case (state)
            IDLE: begin
                if (shadow_full) begin
                    state_nxt = SHIFT0;
                    promote   = 1'b1;
                end
            end
            SHIFT0: state_nxt = SHIFT1;
            SHIFT1: state_nxt = ACTIVE;
            ACTIVE: begin
                if (tile_done) begin
                    if (shadow_full) begin
                        state_nxt = SHIFT0;
                        promote   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shadow_q     <= '0;
            stage_q      <= '0;
            shadow_full  <= 1'b0;
            w_shift      <= 1'b0;
            w_col0       <= 8'd0;
            w_col1       <= 8'd0;
            act_valid    <= 1'b0;
            tiles_loaded <= 8'd0;
            err          <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                shadow_q <= {weight4, weight3, weight2, weight1};
            end
            if (promote) begin
                stage_q     <= shadow_q;
                shadow_full <= 1'b0;
            end else if (accept) begin
                shadow_full <= 1'b1;
            end

            // Outputs are registered from the next state so they line up with it.
            // Entering SHIFT0 always coincides with promotion, so the bottom row comes from shadow.
            w_shift   <= (state_nxt == SHIFT0) || (state_nxt == SHIFT1);
            act_valid <= (state_nxt == ACTIVE);
            case (state_nxt)
                SHIFT0: begin
                    w_col0 <= shadow_q[2];
                    w_col1 <= shadow_q[3];
                end
                SHIFT1: begin
                    w_col0 <= stage_q[0];
                    w_col1 <= stage_q[1];
                end
                default: begin
                    w_col0 <= 8'd0;
                    w_col1 <= 8'd0;
                end
            endcase

            if (state == SHIFT1) begin
                tiles_loaded <= tiles_loaded + 8'd1;
            end
            if (tile_done && (state != ACTIVE)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_weight_stager.sv
// Bench for weight_stager: tile-occupancy model checked every cycle plus hand-computed literal checks.
module tb_weight_stager;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] weight1, weight2, weight3, weight4;
    logic       in_valid;
    logic       in_ready;
    logic       tile_done;
    logic [7:0] w_col0, w_col1;
    logic       w_shift;
    logic       act_valid;
    logic [7:0] tiles_loaded;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    weight_stager dut (
        .clk          (clk),
        .reset        (reset),
        .weight1      (weight1),
        .weight2      (weight2),
        .weight3      (weight3),
        .weight4      (weight4),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .tile_done    (tile_done),
        .w_col0       (w_col0),
        .w_col1       (w_col1),
        .w_shift      (w_shift),
        .act_valid    (act_valid),
        .tiles_loaded (tiles_loaded),
        .err          (err)
    );

    // Model: m_age = -1 array empty, 0 first shift cycle, 1 second shift cycle, >=2 tile resident.
    int         m_age = -1;
    logic       m_sf  = 1'b0;
    logic       m_err = 1'b0;
    logic [7:0] m_cnt = 8'd0;
    logic [7:0] m_sh [4];
    logic [7:0] m_t  [4];
    logic       m_old_sf;
    logic       m_acc;
    logic       m_done_ok;

    always @(posedge clk) begin
        if (reset) begin
            m_age = -1;
            m_sf  = 1'b0;
            m_err = 1'b0;
            m_cnt = 8'd0;
            for (int i = 0; i < 4; i++) begin
                m_sh[i] = 8'd0;
                m_t[i]  = 8'd0;
            end
        end else begin
            m_old_sf  = m_sf;
            m_acc     = in_valid && !m_old_sf;
            m_done_ok = tile_done && (m_age >= 2);
            if (tile_done && (m_age < 2)) m_err = 1'b1;
            if (m_age == 1) m_cnt = m_cnt + 8'd1;
            if (m_age == 0 || m_age == 1) begin
                m_age = m_age + 1;
            end else if (m_age == -1 || m_done_ok) begin
                if (m_old_sf) begin
                    for (int i = 0; i < 4; i++) m_t[i] = m_sh[i];
                    m_sf  = 1'b0;
                    m_age = 0;
                end else begin
                    m_age = -1;
                end
            end
            if (m_acc) begin
                m_sh[0] = weight1;
                m_sh[1] = weight2;
                m_sh[2] = weight3;
                m_sh[3] = weight4;
                m_sf    = 1'b1;
            end
        end
    end

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [27:0] exp_v, act_v;
        logic [7:0]  e_c0, e_c1;
        if (chk_en) begin
            e_c0 = (m_age == 0) ? m_t[2] : (m_age == 1) ? m_t[0] : 8'd0;
            e_c1 = (m_age == 0) ? m_t[3] : (m_age == 1) ? m_t[1] : 8'd0;
            exp_v = {!m_sf, (m_age == 0 || m_age == 1), (m_age >= 2), m_err, e_c0, e_c1, m_cnt};
            act_v = {in_ready, w_shift, act_valid, err, w_col0, w_col1, tiles_loaded};
            n_checks++;
            if (act_v === exp_v) n_pass++;
            else $display("FAIL model_cycle t=%0t {rdy,shift,act,err,c0,c1,cnt} got %h expected %h",
                          $time, act_v, exp_v);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_tile(input logic [7:0] a, b, c, d);
        weight1  = a;
        weight2  = b;
        weight3  = c;
        weight4  = d;
        in_valid = 1'b1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; tile_done = 1'b0;
        weight1 = 8'd0; weight2 = 8'd0; weight3 = 8'd0; weight4 = 8'd0;
        cyc(2);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_w_shift", w_shift, 0);
        chk("rst_act_valid", act_valid, 0);
        chk("rst_tiles_loaded", tiles_loaded, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;

        // single tile: accept {1,2,3,4}
        put_tile(8'd1, 8'd2, 8'd3, 8'd4);
        cyc; in_valid = 1'b0;
        chk("single_in_ready_low", in_ready, 0);
        cyc;
        chk("single_s0_shift", w_shift, 1);
        chk("single_s0_col0", w_col0, 3);
        chk("single_s0_col1", w_col1, 4);
        cyc;
        chk("single_s1_col0", w_col0, 1);
        chk("single_s1_col1", w_col1, 2);
        cyc;
        chk("single_act_valid", act_valid, 1);
        chk("single_tiles_loaded", tiles_loaded, 1);
        chk("single_shift_off", w_shift, 0);

        // back-to-back: B arrives during A's SHIFT1
        reset = 1'b1; cyc; reset = 1'b0;
        put_tile(8'd1, 8'd2, 8'd3, 8'd4);
        cyc; in_valid = 1'b0;
        cyc(2);
        put_tile(8'd5, 8'd6, 8'd7, 8'd8);
        cyc; in_valid = 1'b0;
        chk("b2b_in_ready_low", in_ready, 0);
        chk("b2b_a_active", act_valid, 1);
        cyc(2);
        tile_done = 1'b1;
        cyc; tile_done = 1'b0;
        chk("b2b_no_bubble", w_shift, 1);
        chk("b2b_s0_col0", w_col0, 7);
        chk("b2b_s0_col1", w_col1, 8);
        cyc;
        chk("b2b_s1_col0", w_col0, 5);
        chk("b2b_s1_col1", w_col1, 6);
        cyc;
        chk("b2b_act_valid", act_valid, 1);
        chk("b2b_tiles_loaded", tiles_loaded, 2);

        // backpressure: shadow full, 9s held on the bus must be dropped
        put_tile(8'd10, 8'd11, 8'd12, 8'd13);
        cyc;
        put_tile(8'd9, 8'd9, 8'd9, 8'd9);
        chk("bp_in_ready_low", in_ready, 0);
        cyc(3);
        chk("bp_still_full", in_ready, 0);
        in_valid = 1'b0; tile_done = 1'b1;
        cyc; tile_done = 1'b0;
        chk("bp_in_ready_free", in_ready, 1);
        chk("bp_s0_col0", w_col0, 12);
        chk("bp_s0_col1", w_col1, 13);
        cyc;
        chk("bp_s1_col0", w_col0, 10);
        chk("bp_s1_col1", w_col1, 11);
        cyc;
        tile_done = 1'b1;
        cyc; tile_done = 1'b0;
        chk("bp_idle_after", act_valid, 0);
        chk("bp_no_nines", w_shift, 0);

        // protocol error in IDLE
        reset = 1'b1; cyc; reset = 1'b0;
        tile_done = 1'b1;
        cyc; tile_done = 1'b0;
        chk("perr_err", err, 1);
        cyc;
        chk("perr_stays_idle", w_shift, 0);
        put_tile(8'd31, 8'd32, 8'd33, 8'd34);
        cyc; in_valid = 1'b0;
        cyc(3);
        chk("perr_tile_active", act_valid, 1);
        chk("perr_err_sticky", err, 1);

        // reset during SHIFT1
        tile_done = 1'b1;
        cyc; tile_done = 1'b0;
        put_tile(8'd21, 8'd22, 8'd23, 8'd24);
        cyc; in_valid = 1'b0;
        cyc(2);
        chk("rmid_in_shift1", w_col0, 21);
        reset = 1'b1;
        cyc; reset = 1'b0;
        chk("rmid_w_shift", w_shift, 0);
        chk("rmid_act_valid", act_valid, 0);
        chk("rmid_tiles_loaded", tiles_loaded, 0);
        chk("rmid_in_ready", in_ready, 1);
        chk("rmid_err_cleared", err, 0);
        cyc(2);
        chk("rmid_no_resume", w_shift, 0);

        // wrap after 256 tiles
        for (int i = 0; i < 256; i++) begin
            put_tile(i[7:0], i[7:0] + 8'd1, i[7:0] + 8'd2, i[7:0] + 8'd3);
            cyc; in_valid = 1'b0;
            cyc(3);
            if (i == 0)   chk("wrap_first", tiles_loaded, 1);
            if (i == 254) chk("wrap_255", tiles_loaded, 255);
            tile_done = 1'b1;
            cyc; tile_done = 1'b0;
        end
        chk("wrap_zero", tiles_loaded, 0);
        chk("wrap_err", err, 0);

        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
